// File: rtl/div_iter.sv
// ---------------------------------------------------------------------------
// div_iter -- iterative radix-2 restoring divider (EX-stage responder).
//
// Accepts one DIV/DIVU request while idle, runs WIDTH restoring steps, then
// presents quotient on lo and remainder on hi with a one-cycle out_valid.
// Fixed latency: acceptance in cycle 0, busy in cycles 1..WIDTH, and
// out_valid in cycle WIDTH+1. WIDTH must be at least 2.
//
// Handshake: a request is taken on a rising edge where the block is IDLE,
// in_valid=1 and cancel=0. There is no backpressure on the result.
// out_valid is a single-cycle pulse in DONE. The requester must drop or
// re-purpose in_valid after seeing out_valid, because the next IDLE cycle
// treats in_valid as a new request.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   divide request (level)
//   cancel     synchronous flush, abandons any operation in progress
//   sign       1 = signed (DIV), 0 = unsigned (DIVU)
//   srca/srcb  dividend / divisor, sampled only in the acceptance cycle
//   out_valid  result valid pulse (DONE state)
//   busy       iteration in progress (BUSY state)
//   hi / lo    remainder / quotient, held until the next DONE
//   dbg_state  current FSM state encoding (0 IDLE, 1 BUSY, 2 DONE)
// ---------------------------------------------------------------------------
module div_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             cancel,
   input  logic             sign,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic             out_valid,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [1:0]       dbg_state
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   div_q, div_d;     // divisor magnitude
   logic [WIDTH-1:0]   quo_q, quo_d;     // dividend shifts out, quotient shifts in
   logic [WIDTH-1:0]   rem_q, rem_d;     // partial remainder
   logic [WIDTH-1:0]   raw_a_q, raw_a_d; // unmodified dividend for divide-by-zero
   logic               q_neg_q, q_neg_d;
   logic               r_neg_q, r_neg_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     shifted, trial;
   logic [WIDTH-1:0]   res_lo, res_hi;

   // Operand magnitudes only matter in the acceptance cycle.
   assign a_mag = (sign && srca[WIDTH-1]) ? -srca : srca;
   assign b_mag = (sign && srcb[WIDTH-1]) ? -srcb : srcb;

   // One restoring step: bring the next dividend bit into the remainder and
   // try subtracting the divisor. WIDTH+1 bits keep the borrow visible as MSB
   // even when the shifted remainder overflows WIDTH bits.
   assign shifted = {rem_q, quo_q[WIDTH-1]};
   assign trial   = shifted - {1'b0, div_q};

   // Sign-corrected result, valid while in DONE.
   assign res_lo = dz_q ? '1      : (q_neg_q ? -quo_q : quo_q);
   assign res_hi = dz_q ? raw_a_q : (r_neg_q ? -rem_q : rem_q);

   // In DONE the fresh result is shown directly, so hi/lo are valid in the
   // same cycle as out_valid; the registered copy holds it afterwards.
   assign hi        = (state_q == S_DONE) ? res_hi : hi_q;
   assign lo        = (state_q == S_DONE) ? res_lo : lo_q;
   assign dbg_state = state_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      raw_a_d   = raw_a_q;
      q_neg_d   = q_neg_q;
      r_neg_d   = r_neg_q;
      dz_d      = dz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      out_valid = 1'b0;
      busy      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (in_valid && !cancel) begin
               raw_a_d = srca;
               div_d   = b_mag;
               quo_d   = a_mag;
               rem_d   = '0;
               cnt_d   = '0;
               q_neg_d = sign & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
               r_neg_d = sign & srca[WIDTH-1];
               dz_d    = (srcb == '0);
               state_d = S_BUSY;
            end
         end

         S_BUSY: begin
            busy  = 1'b1;
            rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = S_DONE;
            end
            if (cancel) begin
               state_d = S_IDLE;
            end
         end

         S_DONE: begin
            // in_valid is deliberately ignored here: the request that is
            // still visible belongs to the instruction being completed.
            out_valid = 1'b1;
            hi_d      = res_hi;
            lo_d      = res_lo;
            state_d   = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         raw_a_q <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         raw_a_q <= raw_a_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

endmodule

// File: tb/tb_div_iter.sv
// ---------------------------------------------------------------------------
// tb_div_iter -- directed self-checking bench for div_iter (WIDTH = 32).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. well away from the active edge.
// ---------------------------------------------------------------------------
module tb_div_iter;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        cancel;
   logic        sign;
   logic [31:0] srca;
   logic [31:0] srcb;
   logic        out_valid;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [1:0]  dbg_state;

   int n_chk;
   int n_err;

   div_iter #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .cancel    (cancel),
      .sign      (sign),
      .srca      (srca),
      .srcb      (srcb),
      .out_valid (out_valid),
      .busy      (busy),
      .hi        (hi),
      .lo        (lo),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request in the current (IDLE) cycle and move to cycle 1.
   // Afterwards the operands are scrambled; they must not affect the result.
   task automatic accept(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic hold);
      sign     = s;
      srca     = a;
      srcb     = b;
      in_valid = 1'b1;
      step();
      if (!hold) in_valid = 1'b0;
      srca = ~a;
      srcb = a ^ b ^ 32'h5A5A_0001;
      sign = ~s;
   endtask

   // Entered in cycle 1 after acceptance. Waits (bounded) for out_valid,
   // checks latency, busy length and the result; returns in the DONE cycle.
   task automatic wait_result(input string tag, input logic [31:0] exp_lo,
                              input logic [31:0] exp_hi);
      int cyc;
      int done_cyc;
      int busy_cnt;
      cyc      = 1;
      done_cyc = -1;
      busy_cnt = 0;
      while (cyc <= 40 && done_cyc < 0) begin
         if (out_valid) begin
            done_cyc = cyc;
         end else begin
            if (busy) busy_cnt++;
            srca = srca + 32'h0001_3579;
            srcb = srcb ^ 32'h0000_A5A5;
            step();
            cyc++;
         end
      end
      chk({tag, "_latency"}, done_cyc, 33);
      chk({tag, "_busy_cycles"}, busy_cnt, 32);
      chk({tag, "_busy_in_done"}, {31'd0, busy}, 0);
      chk({tag, "_lo"}, lo, exp_lo);
      chk({tag, "_hi"}, hi, exp_hi);
   endtask

   // Full operation from an IDLE cycle, including the cycle after DONE.
   task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi);
      accept(s, a, b, 1'b0);
      wait_result(tag, exp_lo, exp_hi);
      step();
      chk({tag, "_ov_pulse"}, {31'd0, out_valid}, 0);
      chk({tag, "_lo_hold"}, lo, exp_lo);
      chk({tag, "_hi_hold"}, hi, exp_hi);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic ov_seen;
      n_chk    = 0;
      n_err    = 0;
      rst      = 1'b0;
      in_valid = 1'b0;
      cancel   = 1'b0;
      sign     = 1'b0;
      srca     = '0;
      srcb     = '0;

      repeat (2) step();
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_state", {30'd0, dbg_state}, 0);
      rst = 1'b1;

      // Basic and signed vectors
      run_op("u100_7",    1'b0, 32'd100,        32'd7,          32'd14,         32'd2);
      run_op("s_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF);
      run_op("s_7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1);
      run_op("s_m100_m7", 1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE);
      // Extremes
      run_op("s_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0);
      run_op("u_max_1",   1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0);
      run_op("u_max_max", 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0);
      run_op("u5_9",      1'b0, 32'd5,          32'd9,          32'd0,          32'd5);
      // Divide by zero, signed and unsigned
      run_op("s_dz",      1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678);
      run_op("u_dz",      1'b0, 32'h8765_4321,  32'd0,          32'hFFFF_FFFF,  32'h8765_4321);

      // Cancel while IDLE blocks acceptance
      in_valid = 1'b1;
      cancel   = 1'b1;
      srca     = 32'd9;
      srcb     = 32'd3;
      step();
      chk("cancel_idle_busy", {31'd0, busy}, 0);
      in_valid = 1'b0;
      cancel   = 1'b0;

      // Cancel in cycle 10, restart at cycle 12
      ov_seen = 1'b0;
      accept(1'b0, 32'd100, 32'd7, 1'b0);
      for (int c = 1; c < 10; c++) begin
         ov_seen |= out_valid;
         step();
      end
      chk("cancel_busy_c10", {31'd0, busy}, 1);
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      ov_seen |= out_valid;
      chk("cancel_idle_c11", {30'd0, dbg_state}, 0);
      chk("cancel_busy_c11", {31'd0, busy}, 0);
      step();
      ov_seen |= out_valid;
      chk("cancel_no_ov", {31'd0, ov_seen}, 0);
      run_op("c50_6", 1'b0, 32'd50, 32'd6, 32'd8, 32'd2);

      // Reset in cycle 20 with in_valid held high throughout
      accept(1'b0, 32'd100, 32'd7, 1'b1);
      for (int c = 1; c < 20; c++) begin
         srca = srca + 32'd3;
         step();
      end
      rst = 1'b0;
      #1;
      chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
      chk("mid_rst_busy", {31'd0, busy}, 0);
      chk("mid_rst_hi", hi, 0);
      chk("mid_rst_lo", lo, 0);
      sign = 1'b0;
      srca = 32'd1000;
      srcb = 32'd9;
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      srca = 32'hDEAD_BEEF;
      srcb = 32'd3;
      wait_result("rst_hold", 32'd111, 32'd1);
      // Next instruction's operands become visible during DONE
      sign = 1'b0;
      srca = 32'd20;
      srcb = 32'd3;
      step();
      chk("rst_hold_ov_once", {31'd0, out_valid}, 0);
      chk("rst_hold_idle_busy", {31'd0, busy}, 0);
      step();
      chk("reaccept_busy", {31'd0, busy}, 1);
      in_valid = 1'b0;
      wait_result("next_20_3", 32'd6, 32'd2);
      step();
      chk("next_ov_pulse", {31'd0, out_valid}, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
